// File: rtl/ysyx_220066_nxtpc_bpu.sv
// Next-PC unit: direct-mapped BTB with 2-bit counters, same-cycle IF prediction and EX resolve/train.
// Define YSYX_220066_BPU_STATS_EN to add the stat_branches / stat_mispred counters.
module ysyx_220066_nxtpc_bpu #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_pc,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_busa,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_zero,
    input  logic            ex_result0,
    input  logic [2:0]      ex_branch,
    input  logic [XLEN-1:0] ex_pred_pc,
    output logic            ex_is_jmp,
    output logic [XLEN-1:0] ex_next_pc,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
`ifdef YSYX_220066_BPU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0]                 valid;
    logic [ENTRIES-1:0][1:0]            ctr;
    logic [ENTRIES-1:0][TAG_W-1:0]      tags;
    logic [ENTRIES-1:0][XLEN-1:0]       target;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

    assign if_hit     = valid[if_idx] && (tags[if_idx] == if_tag);
    assign ex_hit     = valid[ex_idx] && (tags[ex_idx] == ex_tag);
    assign pred_taken = if_valid && if_hit && ctr[if_idx][1];
    assign pred_pc    = pred_taken ? target[if_idx] : if_pc + XLEN'(4);

    logic            take;
    logic [XLEN-1:0] base, sum, br_tgt;

    always_comb begin
        take = 1'b0;
        case (ex_branch)
            3'b000:                 take = 1'b0;
            3'b001, 3'b010, 3'b011: take = 1'b1;
            3'b100:                 take = ex_zero;
            3'b101:                 take = !ex_zero;
            3'b110:                 take = ex_result0;
            3'b111:                 take = ex_zero | !ex_result0;
            default:                take = 1'b0;
        endcase
    end

    assign base        = (ex_branch == 3'b010) ? ex_busa : ex_pc;
    assign sum         = base + (take ? ex_imm : XLEN'(4));
    assign ex_next_pc  = (ex_branch == 3'b010) ? {sum[XLEN-1:1], 1'b0} : sum;
    assign br_tgt      = ex_pc + ex_imm;
    assign ex_is_jmp   = ex_valid && ((ex_branch == 3'b010) || take);
    assign redirect    = ex_valid && !rst && (ex_next_pc != ex_pred_pc);
    assign redirect_pc = ex_next_pc;

    logic train_en, is_cond;
    assign train_en = ex_valid && (ex_branch != 3'b000);
    assign is_cond  = ex_branch[2];

    // Valid/counter state is reset; tag/target only matter once valid is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            ctr   <= {ENTRIES{2'b01}};
        end else if (train_en) begin
            if (!is_cond) begin
                valid[ex_idx] <= 1'b1;
                ctr[ex_idx]   <= 2'b11;
            end else if (ex_hit) begin
                if (take && ctr[ex_idx] != 2'b11)
                    ctr[ex_idx] <= ctr[ex_idx] + 2'b01;
                else if (!take && ctr[ex_idx] != 2'b00)
                    ctr[ex_idx] <= ctr[ex_idx] - 2'b01;
            end else if (take) begin
                valid[ex_idx] <= 1'b1;
                ctr[ex_idx]   <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && train_en) begin
            if (!is_cond) begin
                tags[ex_idx]   <= ex_tag;
                target[ex_idx] <= ex_next_pc;
            end else if (ex_hit) begin
                target[ex_idx] <= br_tgt;
            end else if (take) begin
                tags[ex_idx]   <= ex_tag;
                target[ex_idx] <= br_tgt;
            end
        end
    end

`ifdef YSYX_220066_BPU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (train_en) stat_branches <= stat_branches + 32'd1;
            if (redirect) stat_mispred  <= stat_mispred + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_220066_nxtpc_bpu.sv
// Directed + randomized bench for ysyx_220066_nxtpc_bpu against a table-level reference model.
module tb_ysyx_220066_nxtpc_bpu;
    localparam int XLEN = 64, ENTRIES = 16, TAG_W = 8, IDX_W = 4;

    logic            clk = 1'b0, rst = 1'b1;
    logic            if_valid = 1'b0, ex_valid = 1'b0, ex_zero = 1'b0, ex_result0 = 1'b0;
    logic [XLEN-1:0] if_pc = '0, ex_pc = '0, ex_busa = '0, ex_imm = '0, ex_pred_pc = '0;
    logic [2:0]      ex_branch = 3'b000;
    logic            pred_taken, ex_is_jmp, redirect;
    logic [XLEN-1:0] pred_pc, ex_next_pc, redirect_pc;
`ifdef YSYX_220066_BPU_STATS_EN
    logic [31:0]     stat_branches, stat_mispred;
`endif

    ysyx_220066_nxtpc_bpu #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_busa(ex_busa), .ex_imm(ex_imm),
        .ex_zero(ex_zero), .ex_result0(ex_result0), .ex_branch(ex_branch),
        .ex_pred_pc(ex_pred_pc), .ex_is_jmp(ex_is_jmp), .ex_next_pc(ex_next_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef YSYX_220066_BPU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    int ncmp = 0, nerr = 0;

    // reference table
    bit              m_v   [ENTRIES];
    int unsigned     m_tag [ENTRIES];
    logic [XLEN-1:0] m_tgt [ENTRIES];
    int              m_ctr [ENTRIES];
    int unsigned     m_sb = 0, m_sm = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction
    function automatic int unsigned mtag(input logic [XLEN-1:0] pc);
        return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
    endfunction
    function automatic bit mhit(input logic [XLEN-1:0] pc);
        return m_v[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
    endfunction
    function automatic bit mpt(input bit v, input logic [XLEN-1:0] pc);
        return v && mhit(pc) && (m_ctr[midx(pc)] >= 2);
    endfunction
    function automatic logic [XLEN-1:0] mpred(input bit v, input logic [XLEN-1:0] pc);
        return mpt(v, pc) ? m_tgt[midx(pc)] : pc + 64'd4;
    endfunction
    function automatic bit mtake();
        case (ex_branch)
            3'd0: return 1'b0;
            3'd4: return ex_zero;
            3'd5: return !ex_zero;
            3'd6: return ex_result0;
            3'd7: return ex_zero || !ex_result0;
            default: return 1'b1;
        endcase
    endfunction
    function automatic logic [XLEN-1:0] mnext();
        logic [XLEN-1:0] r;
        r = (ex_branch == 3'd2) ? ex_busa : ex_pc;
        r = r + (mtake() ? ex_imm : 64'd4);
        if (ex_branch == 3'd2) r = r & ~64'd1;
        return r;
    endfunction
    function automatic bit mredir();
        return ex_valid && !rst && (mnext() != ex_pred_pc);
    endfunction

    task automatic settle();
        #1;
        chk("pred_taken", {63'd0, pred_taken}, {63'd0, mpt(if_valid, if_pc)});
        chk("pred_pc", pred_pc, mpred(if_valid, if_pc));
        chk("ex_next_pc", ex_next_pc, mnext());
        chk("redirect_pc", redirect_pc, mnext());
        chk("ex_is_jmp", {63'd0, ex_is_jmp}, {63'd0, ex_valid && (ex_branch == 3'd2 || mtake())});
        chk("redirect", {63'd0, redirect}, {63'd0, mredir()});
`ifdef YSYX_220066_BPU_STATS_EN
        chk("stat_branches", {32'd0, stat_branches}, {32'd0, m_sb});
        chk("stat_mispred", {32'd0, stat_mispred}, {32'd0, m_sm});
`endif
    endtask

    task automatic tick();
        int i;
        bit tk;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin m_v[k] = 0; m_ctr[k] = 1; end
            m_sb = 0; m_sm = 0;
        end else begin
            i  = midx(ex_pc);
            tk = mtake();
            if (mredir()) m_sm++;
            if (ex_valid && ex_branch != 3'd0) begin
                m_sb++;
                if (ex_branch < 3'd4) begin
                    m_v[i] = 1; m_tag[i] = mtag(ex_pc); m_tgt[i] = mnext(); m_ctr[i] = 3;
                end else if (mhit(ex_pc)) begin
                    m_tgt[i] = ex_pc + ex_imm;
                    m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                end else if (tk) begin
                    m_v[i] = 1; m_tag[i] = mtag(ex_pc); m_tgt[i] = ex_pc + ex_imm; m_ctr[i] = 2;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [XLEN-1:0] pick_pc();
        return 64'h8000_0000 + 64'($urandom_range(0, 15) * 4) + 64'($urandom_range(0, 3) << 6);
    endfunction

    initial begin
        int ival;
        // reset cycle: table contents are unknown until the first edge
        @(negedge clk);
        ex_valid = 1'b1; ex_branch = 3'd1; ex_pc = 64'h8000_0010; ex_imm = 64'h20;
        #1 chk("redirect_in_rst", {63'd0, redirect}, 64'd0);
        tick();

        // 1: empty table after reset
        rst = 1'b0; ex_valid = 1'b0; ex_branch = 3'd0;
        if_valid = 1'b1; if_pc = 64'h8000_0000;
        settle();
        chk("t1_pred_taken", {63'd0, pred_taken}, 64'd0);
        chk("t1_pred_pc", pred_pc, 64'h8000_0004);
        chk("t1_redirect", {63'd0, redirect}, 64'd0);
        tick();

        // 2: jal trains; lookup of the same index in that cycle sees old contents
        ex_valid = 1'b1; ex_branch = 3'd1; ex_pc = 64'h8000_0010; ex_imm = 64'h20;
        ex_pred_pc = 64'h8000_0014; if_pc = 64'h8000_0010;
        settle();
        chk("t2_redirect", {63'd0, redirect}, 64'd1);
        chk("t2_redirect_pc", redirect_pc, 64'h8000_0030);
        chk("t2_no_bypass", {63'd0, pred_taken}, 64'd0);
        tick();
        ex_valid = 1'b0;
        settle();
        chk("t2_pred_taken", {63'd0, pred_taken}, 64'd1);
        chk("t2_pred_pc", pred_pc, 64'h8000_0030);
        tick();

        // 3: jalr clears bit 0
        ex_valid = 1'b1; ex_branch = 3'd2; ex_pc = 64'h8000_0020; ex_busa = 64'h8000_1001;
        ex_imm = 64'h4; ex_pred_pc = 64'h8000_1004;
        settle();
        chk("t3_next_pc", ex_next_pc, 64'h8000_1004);
        chk("t3_is_jmp", {63'd0, ex_is_jmp}, 64'd1);
        chk("t3_redirect", {63'd0, redirect}, 64'd0);
        tick();

        // 4: beq trained T,T,T,N
        ex_branch = 3'd4; ex_pc = 64'h8000_0040; ex_imm = 64'hFFFF_FFFF_FFFF_FFF8;
        if_pc = 64'h8000_0040;
        for (int k = 0; k < 4; k++) begin
            ex_zero = (k < 3); ex_pred_pc = mpred(1'b1, ex_pc);
            settle();
            chk("t4_redirect", {63'd0, redirect}, {63'd0, (k == 0 || k == 3)});
            if (k == 0) chk("t4_rpc0", redirect_pc, 64'h8000_0038);
            if (k == 3) chk("t4_rpc3", redirect_pc, 64'h8000_0044);
            tick();
        end
        ex_valid = 1'b0;
        settle();
        chk("t4_still_taken", {63'd0, pred_taken}, 64'd1);
        chk("t4_pred_pc", pred_pc, 64'h8000_0038);
        tick();

        // 5: alias on idx 4 with a different tag
        if_pc = 64'h8000_0410;
        settle();
        chk("t5_alias_miss", {63'd0, pred_taken}, 64'd0);
        chk("t5_alias_pc", pred_pc, 64'h8000_0414);
        ex_valid = 1'b1; ex_branch = 3'd1; ex_pc = 64'h8000_0410; ex_imm = 64'h100;
        ex_pred_pc = 64'h8000_0414;
        tick();
        ex_valid = 1'b0;
        settle();
        chk("t5_new_owner", pred_pc, 64'h8000_0510);
        tick();
        if_pc = 64'h8000_0010;
        settle();
        chk("t5_old_evicted", {63'd0, pred_taken}, 64'd0);
        tick();

        // 6: reset during a training write
        rst = 1'b1; ex_valid = 1'b1; ex_branch = 3'd1; ex_pc = 64'h8000_0084;
        ex_imm = 64'h40; ex_pred_pc = 64'h0;
        settle();
        chk("t6_redirect_rst", {63'd0, redirect}, 64'd0);
        tick();
        rst = 1'b0; ex_valid = 1'b0; if_pc = 64'h8000_0084;
        settle();
        chk("t6_entry_invalid", {63'd0, pred_taken}, 64'd0);
`ifdef YSYX_220066_BPU_STATS_EN
        chk("t6_stat_b", {32'd0, stat_branches}, 64'd0);
        chk("t6_stat_m", {32'd0, stat_mispred}, 64'd0);
`endif
        tick();

        // random traffic over a small PC window so entries hit, alias and saturate
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            if_valid   = ($urandom_range(0, 3) != 0);
            if_pc      = pick_pc();
            ex_valid   = ($urandom_range(0, 4) != 0);
            ex_pc      = pick_pc();
            ex_branch  = 3'($urandom_range(0, 7));
            ex_zero    = 1'($urandom_range(0, 1));
            ex_result0 = 1'($urandom_range(0, 1));
            ex_busa    = pick_pc() + 64'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ex_imm = {$urandom, $urandom};
            else begin
                ival   = int'($urandom_range(0, 32)) * 4 - 64;
                ex_imm = 64'(longint'(ival));
            end
            ex_pred_pc = ($urandom_range(0, 3) != 0) ? mpred(1'b1, ex_pc) : pick_pc();
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
